// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice.
// Operands are presented LSB-first; the slice carry is chained through a register.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_binvert,
    output logic             slice_cin,
    output logic [2:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              binv_q, binv_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              legal;
    logic              arith;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            binv_q  <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            binv_q  <= binv_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        res_d         = res_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        binv_d        = binv_q;
        carry_d       = carry_q;
        cout_d        = cout_q;
        ovf_d         = ovf_q;
        zero_d        = zero_q;
        err_d         = err_q;
        hold_d        = 1'b0;
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_binvert = 1'b0;
        slice_cin     = 1'b0;
        slice_op      = 3'b000;
        legal         = (req_op != 3'b101) && (req_op != 3'b111);
        arith         = (op_q == OP_ADD) || (op_q == OP_SUB);

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    cnt_d   = '0;
                    res_d   = '0;
                    binv_d  = (req_op == OP_SUB);
                    carry_d = (req_op == OP_SUB);
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    err_d   = ~legal;
                    // Illegal ops spend one silent cycle in DONE before responding.
                    hold_d  = ~legal;
                    state_d = legal ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                slice_a       = a_q[0];
                slice_b       = b_q[0];
                slice_binvert = binv_q;
                slice_cin     = carry_q;
                slice_op      = op_q;
                res_d         = {slice_result, res_q[WIDTH-1:1]};
                a_d           = a_q >> 1;
                b_d           = b_q >> 1;
                carry_d       = slice_cout;
                cnt_d         = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    ovf_d   = arith & (carry_q ^ slice_cout);
                    cout_d  = arith & slice_cout;
                    zero_d  = (res_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!hold_q && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = rst_n && (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE) && !hold_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule
